// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared control encodings for the pipeline hazard controller.
// Holds the forwarding selects, the FSM state type and the forwarding priority helper.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_e;

    // MEM is the younger producer, so it takes priority over WB. x0 is never forwarded.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] rs,
        input logic [4:0] mem_rd,
        input logic       mem_we,
        input logic [4:0] wb_rd,
        input logic       wb_we
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) begin
            sel = FWD_MEM;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_fwd_unit.sv
// Combinational EX operand forwarding selects and the load-use hazard term.
// Evaluated every cycle irrespective of the controller state.
module hazard_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_write,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       lu
);

    always_comb begin
        fwd_a = fwd_select(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
        fwd_b = fwd_select(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
        lu    = ex_mem_read && (ex_rd != 5'd0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central 5-stage pipeline controller: stalls, flushes, forwarding and the
// MUL/DIV start/done sequencing with a timeout watchdog and performance counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned MD_MAX_CYC = 40,
    parameter int unsigned TO_W       = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_md_op,
    input  logic             ex_redirect,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             md_done,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             md_start,
    output logic             md_busy,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [TO_W-1:0] WDOG_LAST = TO_W'(MD_MAX_CYC - 1);

    state_e            state_q, state_d;
    logic [TO_W-1:0]   wdog_q, wdog_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              lu;

    hazard_fwd_unit u_fwd (
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .ex_rd         (ex_rd),
        .ex_mem_read   (ex_mem_read),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .lu            (lu)
    );

    always_comb begin
        state_d      = state_q;
        wdog_d       = wdog_q;
        timeout_d    = timeout_q;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;
        md_start     = 1'b0;

        unique case (state_q)
            RUN: begin
                if (ex_redirect) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (ex_md_op) begin
                    md_start     = 1'b1;
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    exmem_bubble = 1'b1;
                    wdog_d       = '0;
                    state_d      = MD_BUSY;
                end else if (lu) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            MD_BUSY: begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                exmem_bubble = 1'b1;
                wdog_d       = wdog_q + 1'b1;
                // A done pulse on the watchdog's last cycle still counts as a good result.
                if (md_done || (wdog_q == WDOG_LAST)) begin
                    pc_write     = 1'b1;
                    ifid_write   = 1'b1;
                    exmem_bubble = 1'b0;
                    state_d      = RUN;
                    if (!md_done) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase

        if (rst) begin
            pc_write     = 1'b1;
            ifid_write   = 1'b1;
            ifid_flush   = 1'b0;
            idex_flush   = 1'b0;
            exmem_bubble = 1'b0;
            md_start     = 1'b0;
        end

        stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, ~pc_write};
        flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, ((state_q == RUN) && ex_redirect)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wdog_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wdog_q      <= wdog_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign md_busy    = (state_q == MD_BUSY);
    assign md_timeout = timeout_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule
